// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter between a pulsed debug port and a level-request CPU port onto one system bus.
// Define SYSBUS_ARB_TIMEOUT_EN to compile in the bus watchdog (limit set by TIMEOUT_CYCLES).
module sysbus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [2:0]  dbg_size,
    input  logic        dbg_rd,
    input  logic        dbg_wr,
    output logic        dbg_busy,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_size,
    output logic        cpu_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [2:0]  bus_size,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    input  logic        bus_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        dbg_pend_q, dbg_pend_d;
    logic        dbg_we_q, dbg_we_d;
    logic [31:0] dbg_addr_q, dbg_addr_d;
    logic [31:0] dbg_wdata_q, dbg_wdata_d;
    logic [2:0]  dbg_size_q, dbg_size_d;
    logic        last_dbg_q, last_dbg_d;
    logic        own_dbg_q, own_dbg_d;
    logic        cur_we_q, cur_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  bus_size_q, bus_size_d;
    logic        bus_rd_q, bus_rd_d;
    logic        bus_wr_q, bus_wr_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        cpu_req_v;
    logic        pick_dbg;
    logic        grant_we;
    logic        timeout;

    // cpu_req is still high in the ack cycle; it must not start a second transfer.
    assign cpu_req_v = cpu_req && !cpu_ack_q;
    // last_dbg_q=0 means the CPU was granted last, so debug wins a tie.
    assign pick_dbg  = dbg_pend_q && (!cpu_req_v || !last_dbg_q);
    assign grant_we  = pick_dbg ? dbg_we_q : cpu_we;

    assign dbg_busy  = dbg_pend_q | dbg_rd | dbg_wr;
    assign cpu_ack   = cpu_ack_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_size  = bus_size_q;
    assign bus_rd    = bus_rd_q;
    assign bus_wr    = bus_wr_q;

`ifdef SYSBUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    // Holds 1 while idle so the ISSUE cycle is counted as cycle 1.
    always_comb begin
        wd_cnt_d = CNT_W'(1);
        if (state_q != IDLE) wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_cnt_q <= CNT_W'(1);
        else     wd_cnt_q <= wd_cnt_d;
    end

    assign timeout = (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;

    if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout
    end
`endif

    always_comb begin
        state_d     = state_q;
        dbg_pend_d  = dbg_pend_q;
        dbg_we_d    = dbg_we_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_wdata_d = dbg_wdata_q;
        dbg_size_d  = dbg_size_q;
        last_dbg_d  = last_dbg_q;
        own_dbg_d   = own_dbg_q;
        cur_we_d    = cur_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_size_d  = bus_size_q;
        bus_rd_d    = 1'b0;
        bus_wr_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (!dbg_pend_q && (dbg_rd || dbg_wr)) begin
            dbg_pend_d  = 1'b1;
            dbg_we_d    = dbg_wr;
            dbg_addr_d  = dbg_addr;
            dbg_wdata_d = dbg_wdata;
            dbg_size_d  = dbg_size;
        end

        unique case (state_q)
            IDLE: begin
                if (dbg_pend_q || cpu_req_v) begin
                    state_d     = ISSUE;
                    own_dbg_d   = pick_dbg;
                    last_dbg_d  = pick_dbg;
                    cur_we_d    = grant_we;
                    bus_rd_d    = !grant_we;
                    bus_wr_d    = grant_we;
                    bus_addr_d  = pick_dbg ? dbg_addr_q  : cpu_addr;
                    bus_wdata_d = pick_dbg ? dbg_wdata_q : cpu_wdata;
                    bus_size_d  = pick_dbg ? dbg_size_q  : cpu_size;
                end
            end
            ISSUE, WAIT: begin
                state_d = WAIT;
                if (bus_ready || timeout) begin
                    state_d   = IDLE;
                    rsp_err_d = bus_ready ? bus_err : 1'b1;
                    if (!bus_ready)    rsp_rdata_d = '0;
                    else if (!cur_we_q) rsp_rdata_d = bus_rdata;
                    if (own_dbg_q) dbg_pend_d = 1'b0;
                    else           cpu_ack_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dbg_pend_q  <= 1'b0;
            dbg_we_q    <= 1'b0;
            dbg_addr_q  <= '0;
            dbg_wdata_q <= '0;
            dbg_size_q  <= 3'd2;
            last_dbg_q  <= 1'b0;
            own_dbg_q   <= 1'b0;
            cur_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_size_q  <= 3'd2;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dbg_pend_q  <= dbg_pend_d;
            dbg_we_q    <= dbg_we_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_wdata_q <= dbg_wdata_d;
            dbg_size_q  <= dbg_size_d;
            last_dbg_q  <= last_dbg_d;
            own_dbg_q   <= own_dbg_d;
            cur_we_q    <= cur_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_size_q  <= bus_size_d;
            bus_rd_q    <= bus_rd_d;
            bus_wr_q    <= bus_wr_d;
            cpu_ack_q   <= cpu_ack_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: directed scenarios plus randomized single transactions
// checked against a small reference model of the shared response registers and arbitration order.
module tb_sysbus_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [2:0]  dbg_size;
    logic        dbg_rd, dbg_wr, dbg_busy;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_size;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [2:0]  bus_size;
    logic        bus_rd, bus_wr, bus_ready, bus_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rd  = 0;
    int n_wr  = 0;
    int n_ack = 0;

    // Reference model: shared response registers follow the last completion.
    logic [31:0] m_rdata;
    logic        m_err;

    sysbus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_size(dbg_size),
        .dbg_rd(dbg_rd), .dbg_wr(dbg_wr), .dbg_busy(dbg_busy),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_ack(cpu_ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_size(bus_size),
        .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_rd)  n_rd++;
        if (bus_wr)  n_wr++;
        if (cpu_ack) n_ack++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        dbg_addr = '0; dbg_wdata = '0; dbg_size = 3'd0; dbg_rd = 1'b0; dbg_wr = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_size = 3'd0;
        bus_rdata = '0; bus_ready = 1'b0; bus_err = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs;
        tick;
        tick;
        n_cmp++;
        if ({bus_rd, bus_wr, cpu_ack, dbg_busy, rsp_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got %b want 00000", {bus_rd, bus_wr, cpu_ack, dbg_busy, rsp_err});
        end
        n_cmp++;
        if ({rsp_rdata, bus_addr, bus_wdata} !== 96'h0) begin
            n_bad++; $display("FAIL reset_data got %h %h %h want zeros", rsp_rdata, bus_addr, bus_wdata);
        end
        n_cmp++;
        if (bus_size !== 3'd2) begin
            n_bad++; $display("FAIL reset_bus_size got %0d want 2", bus_size);
        end
        rst = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;
        tick;
    endtask

    task automatic test_dbg_read;
        int rd0, wr0;
        logic busy_ok;
        busy_ok = 1'b1;
        tick;                                        // cycle 0
        rd0 = n_rd; wr0 = n_wr;
        dbg_addr = 32'h4000_0010; dbg_size = 3'd2; dbg_wdata = $urandom; dbg_rd = 1'b1;
        #1 busy_ok &= dbg_busy;
        tick;                                        // cycle 1
        dbg_rd = 1'b0; dbg_addr = $urandom;
        #1 busy_ok &= dbg_busy;
        tick;                                        // cycle 2: strobe
        busy_ok &= dbg_busy;
        n_cmp++;
        if ({bus_rd, bus_wr, bus_addr, bus_size} !== {1'b1, 1'b0, 32'h4000_0010, 3'd2}) begin
            n_bad++; $display("FAIL dbg_read_issue got rd=%b wr=%b addr=%h size=%0d want rd=1 wr=0 addr=40000010 size=2",
                              bus_rd, bus_wr, bus_addr, bus_size);
        end
        for (int c = 3; c <= 5; c++) begin
            tick;
            busy_ok &= dbg_busy;
            if (c == 5) begin bus_ready = 1'b1; bus_rdata = 32'h1234_5678; bus_err = 1'b0; end
        end
        tick;                                        // cycle 6
        bus_ready = 1'b0; bus_rdata = $urandom; bus_err = 1'b1;
        m_rdata = 32'h1234_5678; m_err = 1'b0;
        n_cmp++;
        if ({dbg_busy, rsp_rdata, rsp_err} !== {1'b0, m_rdata, m_err}) begin
            n_bad++; $display("FAIL dbg_read_done got busy=%b rdata=%h err=%b want busy=0 rdata=%h err=%b",
                              dbg_busy, rsp_rdata, rsp_err, m_rdata, m_err);
        end
        n_cmp++;
        if (!busy_ok) begin
            n_bad++; $display("FAIL dbg_read_busy got a low dbg_busy before completion want high");
        end
        n_cmp++;
        if ((n_rd - rd0) != 1 || n_wr != wr0) begin
            n_bad++; $display("FAIL dbg_read_strobes got rd=%0d wr=%0d want rd=1 wr=0", n_rd - rd0, n_wr - wr0);
        end
        bus_err = 1'b0;
    endtask

    task automatic test_cpu_write_err;
        int a0;
        logic [31:0] wd;
        wd = $urandom;
        tick;                                        // cycle 0
        a0 = n_ack;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = wd; cpu_size = 3'd2;
        tick;                                        // cycle 1: strobe
        n_cmp++;
        if ({bus_rd, bus_wr, bus_addr, bus_wdata} !== {1'b0, 1'b1, 32'h0, wd}) begin
            n_bad++; $display("FAIL cpu_wr_issue got rd=%b wr=%b addr=%h wdata=%h want rd=0 wr=1 addr=0 wdata=%h",
                              bus_rd, bus_wr, bus_addr, bus_wdata, wd);
        end
        tick;
        tick;                                        // cycle 3
        bus_ready = 1'b1; bus_err = 1'b1; bus_rdata = $urandom;
        tick;                                        // cycle 4: ack
        bus_ready = 1'b0; bus_err = 1'b0;
        m_err = 1'b1;
        n_cmp++;
        if ({cpu_ack, rsp_err, rsp_rdata} !== {1'b1, 1'b1, m_rdata}) begin
            n_bad++; $display("FAIL cpu_wr_err got ack=%b err=%b rdata=%h want ack=1 err=1 rdata=%h",
                              cpu_ack, rsp_err, rsp_rdata, m_rdata);
        end
        cpu_req = 1'b0;
        tick;
        n_cmp++;
        if (cpu_ack !== 1'b0 || (n_ack - a0) != 1) begin
            n_bad++; $display("FAIL cpu_wr_ack_pulse got ack=%b count=%0d want ack=0 count=1", cpu_ack, n_ack - a0);
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] ad;
        ad = $urandom;
        tick;                                        // cycle 0
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ad; cpu_wdata = $urandom; cpu_size = 3'd1;
        tick;                                        // cycle 1
        n_cmp++;
        if ({bus_wr, bus_addr, bus_size} !== {1'b1, ad, 3'd1}) begin
            n_bad++; $display("FAIL zero_wait_strobe got wr=%b addr=%h size=%0d want wr=1 addr=%h size=1",
                              bus_wr, bus_addr, bus_size, ad);
        end
        bus_ready = 1'b1; bus_err = 1'b0;
        tick;                                        // cycle 2
        bus_ready = 1'b0;
        m_err = 1'b0;
        n_cmp++;
        if ({cpu_ack, rsp_err} !== {1'b1, m_err}) begin
            n_bad++; $display("FAIL zero_wait_ack got ack=%b err=%b want ack=1 err=0", cpu_ack, rsp_err);
        end
        cpu_req = 1'b0;
        tick;                                        // cycle 3
        n_cmp++;
        if ({cpu_ack, bus_rd, bus_wr} !== 3'b000) begin
            n_bad++; $display("FAIL zero_wait_after got ack/rd/wr=%b want 000", {cpu_ack, bus_rd, bus_wr});
        end
    endtask

    task automatic test_round_robin;
        string order;
        logic [31:0] daddr, caddr;
        order = "";
        daddr = 32'hD000_0000 | ($urandom & 32'h0000_FFFC);
        caddr = 32'hC000_0000 | ($urandom & 32'h0000_FFFC);
        // Both sides kept requesting: debug first, then strict alternation.
        tick;
        dbg_wr = 1'b1; dbg_addr = daddr; dbg_wdata = $urandom; dbg_size = 3'd2;
        tick;
        dbg_wr = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = caddr; cpu_wdata = $urandom; cpu_size = 3'd2;
        for (int cyc = 0; cyc < 40 && order.len() < 4; cyc++) begin
            tick;
            bus_ready = 1'b0;
            dbg_wr    = 1'b0;
            if (bus_rd || bus_wr) begin
                order = {order, (bus_addr == daddr) ? "D" : "C"};
                bus_ready = 1'b1;
            end
            #1 if (!dbg_busy) dbg_wr = 1'b1;
        end
        n_cmp++;
        if (order != "DCDC") begin
            n_bad++; $display("FAIL rr_order got %s want DCDC", order);
        end
        idle_inputs;
        do_reset;
        // Tie with debug granted last: CPU must win.
        tick;                                        // cycle 0
        dbg_wr = 1'b1; dbg_addr = daddr;
        tick;                                        // cycle 1: D granted alone
        dbg_wr = 1'b0;
        tick;                                        // cycle 2: D strobe
        bus_ready = 1'b1;
        tick;                                        // cycle 3: idle, nothing pending
        bus_ready = 1'b0;
        dbg_wr = 1'b1; dbg_addr = daddr;
        tick;                                        // cycle 4: dbg pending, cpu arrives
        dbg_wr = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = caddr;
        tick;                                        // cycle 5: strobe
        n_cmp++;
        if ((bus_rd || bus_wr) !== 1'b1 || bus_addr !== caddr) begin
            n_bad++; $display("FAIL rr_tie_after_dbg got strobe=%b addr=%h want strobe=1 addr=%h",
                              bus_rd | bus_wr, bus_addr, caddr);
        end
        idle_inputs;
        do_reset;
    endtask

    task automatic test_random;
        logic        is_dbg, we, err;
        logic [31:0] addr, wdata, rdata;
        logic [2:0]  size;
        int          wt, lat, bad_hold;
        for (int it = 0; it < 24; it++) begin
            is_dbg = 1'($urandom_range(0, 1));
            we     = 1'($urandom_range(0, 1));
            err    = 1'($urandom_range(0, 1));
            addr   = $urandom;
            wdata  = $urandom;
            rdata  = $urandom;
            size   = 3'($urandom_range(0, 2));
            wt     = $urandom_range(0, 3);
            tick;                                    // cycle 0
            if (is_dbg) begin
                dbg_rd = !we; dbg_wr = we; dbg_addr = addr; dbg_wdata = wdata; dbg_size = size;
            end else begin
                cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_size = size;
            end
            lat = 0;
            do begin
                tick;
                lat++;
                dbg_rd = 1'b0; dbg_wr = 1'b0;
                dbg_addr = $urandom; dbg_wdata = $urandom; dbg_size = 3'($urandom_range(0, 7));
            end while (!(bus_rd || bus_wr) && lat < 8);
            n_cmp++;
            if (lat != (is_dbg ? 2 : 1)) begin
                n_bad++; $display("FAIL rnd_latency it=%0d got %0d want %0d", it, lat, is_dbg ? 2 : 1);
            end
            n_cmp++;
            if ({bus_rd, bus_wr, bus_addr, bus_wdata, bus_size} !== {!we, we, addr, wdata, size}) begin
                n_bad++; $display("FAIL rnd_issue it=%0d got rd=%b wr=%b addr=%h wdata=%h size=%0d want rd=%b wr=%b addr=%h wdata=%h size=%0d",
                                  it, bus_rd, bus_wr, bus_addr, bus_wdata, bus_size, !we, we, addr, wdata, size);
            end
            bad_hold = 0;
            for (int w = 0; w <= wt; w++) begin
                if (w > 0) begin
                    tick;
                    if ({bus_rd, bus_wr, bus_addr, bus_wdata, bus_size} !== {2'b00, addr, wdata, size}) bad_hold++;
                    if (is_dbg ? (dbg_busy !== 1'b1) : (cpu_ack !== 1'b0)) bad_hold++;
                end
                if (w == wt) begin bus_ready = 1'b1; bus_err = err; bus_rdata = rdata; end
            end
            n_cmp++;
            if (bad_hold != 0) begin
                n_bad++; $display("FAIL rnd_hold it=%0d got %0d bad wait cycles want 0", it, bad_hold);
            end
            tick;                                    // completion visible
            bus_ready = 1'b0; bus_err = 1'($urandom); bus_rdata = $urandom;
            if (!we) m_rdata = rdata;
            m_err = err;
            n_cmp++;
            if ({is_dbg ? ~dbg_busy : cpu_ack, rsp_rdata, rsp_err} !== {1'b1, m_rdata, m_err}) begin
                n_bad++; $display("FAIL rnd_done it=%0d got done=%b rdata=%h err=%b want done=1 rdata=%h err=%b",
                                  it, is_dbg ? ~dbg_busy : cpu_ack, rsp_rdata, rsp_err, m_rdata, m_err);
            end
            cpu_req = 1'b0;
            tick;
            n_cmp++;
            if ({cpu_ack, dbg_busy, bus_rd, bus_wr} !== 4'b0000) begin
                n_bad++; $display("FAIL rnd_quiet it=%0d got ack/busy/rd/wr=%b want 0000",
                                  it, {cpu_ack, dbg_busy, bus_rd, bus_wr});
            end
            bus_err = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        int a0;
        tick;                                        // cycle 0
        dbg_rd = 1'b1; dbg_addr = $urandom; dbg_size = 3'd2;
        tick;
        dbg_rd = 1'b0;
        tick;                                        // ISSUE
        tick;                                        // WAIT
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dbg_busy, bus_rd, bus_wr} !== 3'b000) begin
            n_bad++; $display("FAIL rst_mid_outputs got busy/rd/wr=%b want 000", {dbg_busy, bus_rd, bus_wr});
        end
        tick;
        rst = 1'b0;
        m_rdata = '0; m_err = 1'b0;
        a0 = n_ack;
        tick;
        bus_ready = 1'b1; bus_rdata = $urandom | 32'h1; bus_err = 1'b1;
        tick;
        bus_ready = 1'b0; bus_err = 1'b0;
        tick;
        n_cmp++;
        if ((n_ack - a0) != 0 || {rsp_rdata, rsp_err, dbg_busy} !== {m_rdata, m_err, 1'b0}) begin
            n_bad++; $display("FAIL rst_mid_stray got acks=%0d rdata=%h err=%b busy=%b want acks=0 rdata=%h err=%b busy=0",
                              n_ack - a0, rsp_rdata, rsp_err, dbg_busy, m_rdata, m_err);
        end
    endtask

    task automatic test_timeout;
        logic busy_ok;
        logic [31:0] rdata;
`ifdef SYSBUS_ARB_TIMEOUT_EN
        // v=0: slave silent, watchdog fires; v=1: ready on the limit cycle wins.
        for (int v = 0; v < 2; v++) begin
            busy_ok = 1'b1;
            rdata   = $urandom;
            tick;                                    // cycle 0
            dbg_rd = 1'b1; dbg_addr = $urandom; dbg_size = 3'd2;
            tick;                                    // cycle 1
            dbg_rd = 1'b0;
            for (int c = 2; c < 2 + TO; c++) begin
                tick;
                busy_ok &= dbg_busy;
                if (v == 1 && c == 2 + TO - 1) begin bus_ready = 1'b1; bus_rdata = rdata; bus_err = 1'b0; end
            end
            tick;
            bus_ready = 1'b0;
            m_rdata = (v == 0) ? 32'h0 : rdata;
            m_err   = (v == 0);
            n_cmp++;
            if (!busy_ok || {dbg_busy, rsp_err, rsp_rdata} !== {1'b0, m_err, m_rdata}) begin
                n_bad++; $display("FAIL timeout_v%0d got early_drop=%b busy=%b err=%b rdata=%h want early_drop=0 busy=0 err=%b rdata=%h",
                                  v, !busy_ok, dbg_busy, rsp_err, rsp_rdata, m_err, m_rdata);
            end
        end
`else
        busy_ok = 1'b1;
        rdata   = '0;
        tick;
        dbg_rd = 1'b1; dbg_addr = $urandom; dbg_size = 3'd2;
        tick;
        dbg_rd = 1'b0;
        for (int c = 0; c < 4 * TO; c++) begin
            tick;
            busy_ok &= dbg_busy;
        end
        n_cmp++;
        if (!busy_ok || rsp_rdata !== (m_rdata | rdata)) begin
            n_bad++; $display("FAIL no_timeout got busy_held=%b rdata=%h want busy_held=1 rdata=%h",
                              busy_ok, rsp_rdata, m_rdata);
        end
        do_reset;
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs;
        test_reset;
        test_dbg_read;
        test_cpu_write_err;
        test_zero_wait;
        test_round_robin;
        test_random;
        test_reset_mid;
        test_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, bus watchdog limit in cycles; used only when the watchdog is compiled in.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 dbg_addr  in  32  debug system-bus address.
REQ-006 dbg_wdata  in  32  debug write data.
REQ-007 dbg_size  in  3  debug access size: 0=byte, 1=half, 2=word.
REQ-008 dbg_rd  in  1  debug read strobe, one-cycle pulse.
REQ-009 dbg_wr  in  1  debug write strobe, one-cycle pulse.
REQ-010 dbg_busy  out  1  debug transaction outstanding.
REQ-011 cpu_req  in  1  CPU request, level; held with stable fields until cpu_ack.
REQ-012 cpu_we  in  1  CPU direction: 1=write.
REQ-013 cpu_addr  in  32  CPU address.
REQ-014 cpu_wdata  in  32  CPU write data.
REQ-015 cpu_size  in  3  CPU access size, same encoding as dbg_size.
REQ-016 cpu_ack  out  1  CPU completion, one-cycle pulse.
REQ-017 rsp_rdata  out  32  read data of the last completed read, shared by both requesters.
REQ-018 rsp_err  out  1  error flag of the last completed transaction, shared.
REQ-019 bus_addr  out  32  downstream address.
REQ-020 bus_wdata  out  32  downstream write data.
REQ-021 bus_size  out  3  downstream access size, passed through unmodified.
REQ-022 bus_rd / bus_wr  out  1 each  downstream read/write strobes, one-cycle pulses.
REQ-023 bus_rdata  in  32  downstream read data, valid with bus_ready.
REQ-024 bus_ready  in  1  downstream completion, one-cycle pulse.
REQ-025 bus_err  in  1  downstream error, valid with bus_ready.

Function
REQ-026 A dbg_rd or dbg_wr pulse while no debug transaction is pending SHALL latch address, data, size and direction and set dbg_pend; a pulse while dbg_pend=1 SHALL be ignored.
REQ-027 dbg_busy SHALL equal dbg_pend | dbg_rd | dbg_wr (combinational), so busy is high in the strobe cycle.
REQ-028 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-029 IDLE SHALL grant on dbg_pend or cpu_req and enter ISSUE next cycle; it SHALL ignore bus_ready.
REQ-030 When both are requesting, grant SHALL go to the requester not granted last (round-robin); last_grant resets to CPU, so debug wins first.
REQ-031 ISSUE SHALL assert exactly one of bus_rd/bus_wr for one cycle, with bus_addr, bus_wdata and bus_size from the granted source; those fields SHALL then be held through WAIT.
REQ-032 bus_ready sampled in ISSUE or WAIT SHALL complete the transaction and return the FSM to IDLE.
REQ-033 On completion, rsp_err SHALL be set to bus_err; rsp_rdata SHALL be set to bus_rdata on reads and left unchanged on writes.
REQ-034 On a debug completion, dbg_pend SHALL clear, so dbg_busy is low from the next cycle with rsp_* valid.
REQ-035 On a CPU completion, cpu_ack SHALL be high in the next cycle with rsp_* valid; cpu_req SHALL not be re-sampled in the cycle cpu_ack is high.
REQ-036 Latency: cpu_req in cycle 0 with a zero-wait slave SHALL give bus strobe in cycle 1 and cpu_ack in cycle 2; a debug pulse in cycle 0 SHALL give the bus strobe in cycle 2.

Reset
REQ-037 On reset, all outputs SHALL be 0 except bus_size=3'd2; the FSM SHALL go to IDLE, dbg_pend SHALL clear and last_grant SHALL be CPU.
REQ-038 Reset mid-transaction SHALL drop the transaction with no ack; a later stray bus_ready SHALL be ignored.

Configuration
REQ-039 With SYSBUS_ARB_TIMEOUT_EN defined, a counter SHALL run from ISSUE (inclusive); if there is no bus_ready by the TIMEOUT_CYCLES-th cycle, the transaction SHALL complete in that cycle with rsp_err=1 and rsp_rdata=0; bus_ready in the same cycle SHALL win.
REQ-040 Without SYSBUS_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL last indefinitely.

Verification
REQ-041 dbg_rd addr 0x40000010 size 2, bus_ready 3 cycles after the strobe with rdata 0x12345678 -> single bus_rd; dbg_busy high from the pulse cycle until completion; rsp_rdata=0x12345678, rsp_err=0.
REQ-042 dbg_wr and cpu_req both pending continuously for 4 transactions -> grant order D,C,D,C.
REQ-043 CPU write to 0x00000000 with bus_err=1 on bus_ready -> one cpu_ack pulse with rsp_err=1; rsp_rdata unchanged.
REQ-044 Zero-wait slave (bus_ready in ISSUE) -> cpu_req in cycle 0, bus_wr in cycle 1, cpu_ack in cycle 2.
REQ-045 rst pulsed during WAIT of a debug read -> dbg_busy=0 and bus strobes=0; a later bus_ready produces no cpu_ack and no rsp change.
REQ-046 Macro on, TIMEOUT_CYCLES=16, slave never ready -> completion in the 16th cycle from ISSUE with rsp_err=1; macro off -> dbg_busy stays high.
